division_arbiter: RTL and testbench



---
 rtl/division_arbiter_pkg.sv | 12 +
 rtl/division.sv | 57 +++++
 rtl/division_arbiter.sv | 136 +++++++++++++
 tb/tb_division_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/division_arbiter_pkg.sv
// Shared encodings and constants for the divider arbiter slice.
package division_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [15:0] DIV_ZERO_Q  = 16'hFFFF;
    localparam logic [15:0] DEF_TIMEOUT = 16'd64;

endpackage

// File: rtl/division.sv
// Serial restoring divider, 32/16 unsigned, quotient truncated to 16 bits.
// Latency: one load cycle plus 32 shift cycles after i_cal_sig rises.
// No backpressure: o_cal_done holds while i_cal_sig stays high; dropping i_cal_sig restarts.
module division (
    input  logic        i_clk_50m,
    input  logic        i_rst_n,
    input  logic        i_cal_sig,
    input  logic [31:0] i_dividend,
    input  logic [15:0] i_divisor,
    output logic [15:0] o_quotient,
    output logic [15:0] o_remainder,
    output logic        o_cal_done
);

    logic        r_run;
    logic [4:0]  r_cnt;
    logic [31:0] r_q;
    logic [15:0] r_r;
    logic [16:0] w_trial;
    logic [16:0] w_diff;
    logic        w_ge;

    // r_r is always below the divisor, so the shifted trial fits in 17 bits
    assign w_trial = {r_r, r_q[31]};
    assign w_diff  = w_trial - {1'b0, i_divisor};
    assign w_ge    = (w_trial >= {1'b0, i_divisor});

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run      <= 1'b0;
            r_cnt      <= '0;
            r_q        <= '0;
            r_r        <= '0;
            o_cal_done <= 1'b0;
        end else if (!i_cal_sig) begin
            r_run      <= 1'b0;
            o_cal_done <= 1'b0;
        end else if (!r_run && !o_cal_done) begin
            r_q   <= i_dividend;
            r_r   <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_q   <= {r_q[30:0], w_ge};
            r_r   <= w_ge ? w_diff[15:0] : w_trial[15:0];
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_run      <= 1'b0;
                o_cal_done <= 1'b1;
            end
        end
    end

    assign o_quotient  = r_q[15:0];
    assign o_remainder = r_r;

endmodule

// File: rtl/division_arbiter.sv
// Round-robin arbiter sharing one serial divider among N_REQ clients.
// Latency: D+3 cycles per request (D = divider latency), 3 cycles for divide-by-zero.
// Clients hold i_req until their one-cycle o_ack; no other backpressure.
module division_arbiter
    import division_arbiter_pkg::*;
#(
    parameter int          N_REQ   = 4,
    parameter logic [15:0] TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  i_clk_50m,
    input  logic                  i_rst_n,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [32*N_REQ-1:0]   i_dividend,
    input  logic [16*N_REQ-1:0]   i_divisor,
    output logic [N_REQ-1:0]      o_ack,
    output logic [15:0]           o_quotient,
    output logic [15:0]           o_remainder,
    output logic                  o_err,
    output logic                  o_busy,
    output logic [1:0]            o_grant_id
);

    logic [1:0]       r_state;
    logic [1:0]       r_ptr;
    logic [15:0]      r_tmo;
    logic [31:0]      r_dividend;
    logic [15:0]      r_divisor;
    logic             cal_sig;
    logic             w_cal_done;
    logic [15:0]      w_div_q;
    logic [15:0]      w_div_r;
    logic [31:0]      w_sel_dividend;
    logic [15:0]      w_sel_divisor;
    logic [N_REQ-1:0] w_grant_oh;
    logic             w_tmo_hit;

    function automatic logic [1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int k;
            k = (int'(ptr) + i) % N_REQ;
            if (!found && req[k]) begin
                idx   = 2'(k);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign w_sel_dividend = i_dividend[32*o_grant_id +: 32];
    assign w_sel_divisor  = i_divisor[16*o_grant_id +: 16];
    assign w_grant_oh     = N_REQ'(1) << o_grant_id;
    assign w_tmo_hit      = (r_tmo == TIMEOUT - 16'd1);

    // Drop the start strobe in the completing/aborting cycle so the divider restarts cleanly
    assign cal_sig = (r_state == ST_CALC) && !w_cal_done && !w_tmo_hit;

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_tmo       <= '0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            o_ack       <= '0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_grant_id  <= '0;
        end else begin
            o_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|i_req) begin
                        o_grant_id <= rr_pick(i_req, r_ptr);
                        o_busy     <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_dividend <= w_sel_dividend;
                    r_divisor  <= w_sel_divisor;
                    r_tmo      <= '0;
                    if (w_sel_divisor == 16'd0) begin
                        o_quotient  <= DIV_ZERO_Q;
                        o_remainder <= w_sel_dividend[15:0];
                        o_err       <= 1'b1;
                        o_ack       <= w_grant_oh;
                        r_state     <= ST_RESP;
                    end else begin
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (w_cal_done) begin
                        o_quotient  <= w_div_q;
                        o_remainder <= w_div_r;
                        o_err       <= 1'b0;
                        o_ack       <= w_grant_oh;
                        r_state     <= ST_RESP;
                    end else if (w_tmo_hit) begin
                        o_quotient  <= DIV_ZERO_Q;
                        o_remainder <= '0;
                        o_err       <= 1'b1;
                        o_ack       <= w_grant_oh;
                        r_state     <= ST_RESP;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                ST_RESP: begin
                    r_ptr   <= (o_grant_id == 2'(N_REQ-1)) ? 2'd0 : o_grant_id + 2'd1;
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    division u_div (
        .i_clk_50m   (i_clk_50m),
        .i_rst_n     (i_rst_n),
        .i_cal_sig   (cal_sig),
        .i_dividend  (r_dividend),
        .i_divisor   (r_divisor),
        .o_quotient  (w_div_q),
        .o_remainder (w_div_r),
        .o_cal_done  (w_cal_done)
    );

endmodule

// File: tb/tb_division_arbiter.sv
// Directed bench for division_arbiter: round-robin order, results, divide-by-zero, timeout, reset abort.
module tb_division_arbiter;

    // Divider latency counted inclusively from the first cal_sig cycle to the cal_done cycle
    localparam int DIV_D   = 34;
    localparam int TMO     = 64;

    logic         clk;
    logic         rst_n;
    logic [3:0]   i_req;
    logic [127:0] i_dividend;
    logic [63:0]  i_divisor;
    logic [3:0]   o_ack;
    logic [15:0]  o_quotient;
    logic [15:0]  o_remainder;
    logic         o_err;
    logic         o_busy;
    logic [1:0]   o_grant_id;

    int total = 0;
    int bad   = 0;
    int cal_cnt = 0;

    division_arbiter #(.N_REQ(4), .TIMEOUT(16'd64)) dut (
        .i_clk_50m   (clk),
        .i_rst_n     (rst_n),
        .i_req       (i_req),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_ack       (o_ack),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_err       (o_err),
        .o_busy      (o_busy),
        .o_grant_id  (o_grant_id)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) if (dut.cal_sig) cal_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int k, input logic [31:0] dvd, input logic [15:0] dvs);
        i_dividend[32*k +: 32] = dvd;
        i_divisor[16*k +: 16]  = dvs;
    endtask

    // cyc counts inclusively: the cycle in which i_req is raised is cycle 1
    task automatic wait_ack(output int cyc, output logic [3:0] ack, output logic [15:0] q,
                            output logic [15:0] r, output logic err);
        cyc = 1; ack = '0; q = '0; r = '0; err = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            cyc++;
            if (|o_ack) begin
                ack = o_ack; q = o_quotient; r = o_remainder; err = o_err;
                break;
            end
        end
    endtask

    initial begin
        int          cyc;
        logic [3:0]  ack;
        logic [15:0] q;
        logic [15:0] r;
        logic        err;
        int          stray;
        int          exp_id [5];
        exp_id = '{0, 1, 2, 3, 0};

        rst_n = 1'b0; i_req = '0; i_dividend = '0; i_divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_ack",   32'(o_ack), 32'h0);
        check("rst_quot",  32'(o_quotient), 32'h0);
        check("rst_rem",   32'(o_remainder), 32'h0);
        check("rst_err",   32'(o_err), 32'h0);
        check("rst_busy",  32'(o_busy), 32'h0);
        check("rst_grant", 32'(o_grant_id), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All four clients request at once and keep holding
        for (int k = 0; k < 4; k++) set_op(k, 32'd2700000, 16'd1000);
        i_req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_ack(cyc, ack, q, r, err);
            check($sformatf("rr_ack%0d", j),   32'(ack), 32'(4'b0001 << exp_id[j]));
            check($sformatf("rr_grant%0d", j), 32'(o_grant_id), 32'(exp_id[j]));
            check($sformatf("rr_quot%0d", j),  32'(q), 32'd2700);
            check($sformatf("rr_rem%0d", j),   32'(r), 32'd0);
            check($sformatf("rr_err%0d", j),   32'(err), 32'd0);
        end
        @(negedge clk); i_req = '0;
        repeat (3) @(negedge clk);

        // Single request on client 0 with latency measurement
        set_op(0, 32'h000DBBA0, 16'd1000);
        i_req = 4'b0001;
        wait_ack(cyc, ack, q, r, err);
        check("one_ack",  32'(ack), 32'h1);
        check("one_quot", 32'(q), 32'd900);
        check("one_rem",  32'(r), 32'd0);
        check("one_err",  32'(err), 32'd0);
        check("one_busy", 32'(o_busy), 32'd1);
        check("one_lat",  32'(cyc), 32'(DIV_D + 3));
        @(negedge clk); i_req = '0;
        @(posedge clk); #1;
        check("one_ack_pulse", 32'(o_ack), 32'h0);
        check("one_quot_hold", 32'(o_quotient), 32'd900);
        check("one_idle_busy", 32'(o_busy), 32'd0);
        repeat (2) @(negedge clk);

        // Divide by zero on client 2: no divider start
        set_op(2, 32'h12345678, 16'd0);
        cal_cnt = 0;
        i_req = 4'b0100;
        wait_ack(cyc, ack, q, r, err);
        check("dbz_ack",  32'(ack), 32'h4);
        check("dbz_quot", 32'(q), 32'hFFFF);
        check("dbz_rem",  32'(r), 32'h5678);
        check("dbz_err",  32'(err), 32'd1);
        check("dbz_lat",  32'(cyc), 32'd3);
        @(negedge clk); i_req = '0;
        repeat (2) @(negedge clk);
        check("dbz_no_cal", 32'(cal_cnt), 32'd0);

        // Quotient truncation: 100000 / 1 on client 1
        set_op(1, 32'd100000, 16'd1);
        i_req = 4'b0010;
        wait_ack(cyc, ack, q, r, err);
        check("trunc_ack",  32'(ack), 32'h2);
        check("trunc_quot", 32'(q), 32'h86A0);
        check("trunc_rem",  32'(r), 32'd0);
        check("trunc_err",  32'(err), 32'd0);
        @(negedge clk); i_req = '0;
        repeat (2) @(negedge clk);

        // Divider never completes: arbiter must abort
        force dut.w_cal_done = 1'b0;
        set_op(3, 32'd5000, 16'd7);
        i_req = 4'b1000;
        wait_ack(cyc, ack, q, r, err);
        check("tmo_ack",  32'(ack), 32'h8);
        check("tmo_quot", 32'(q), 32'hFFFF);
        check("tmo_rem",  32'(r), 32'd0);
        check("tmo_err",  32'(err), 32'd1);
        check("tmo_lat",  32'(cyc), 32'(TMO + 3));
        check("tmo_cal_low", 32'(dut.cal_sig), 32'd0);
        @(negedge clk); i_req = '0;
        release dut.w_cal_done;
        repeat (2) @(negedge clk);

        set_op(0, 32'd5000, 16'd7);
        i_req = 4'b0001;
        wait_ack(cyc, ack, q, r, err);
        check("post_tmo_ack",  32'(ack), 32'h1);
        check("post_tmo_quot", 32'(q), 32'd714);
        check("post_tmo_rem",  32'(r), 32'd2);
        check("post_tmo_err",  32'(err), 32'd0);
        @(negedge clk); i_req = '0;
        repeat (2) @(negedge clk);

        // Reset during CALC
        set_op(2, 32'd900000, 16'd1000);
        i_req = 4'b0100;
        repeat (10) @(negedge clk);
        check("mid_busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack",   32'(o_ack), 32'h0);
        check("mid_rst_quot",  32'(o_quotient), 32'h0);
        check("mid_rst_rem",   32'(o_remainder), 32'h0);
        check("mid_rst_err",   32'(o_err), 32'h0);
        check("mid_rst_busy",  32'(o_busy), 32'h0);
        check("mid_rst_grant", 32'(o_grant_id), 32'h0);
        repeat (2) @(negedge clk);
        i_req = '0;
        rst_n = 1'b1;
        stray = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (|o_ack) stray++;
        end
        check("mid_no_ack", 32'(stray), 32'd0);
        @(negedge clk);

        set_op(1, 32'd2700000, 16'd1000);
        i_req = 4'b0010;
        wait_ack(cyc, ack, q, r, err);
        check("fresh_ack",   32'(ack), 32'h2);
        check("fresh_grant", 32'(o_grant_id), 32'd1);
        check("fresh_quot",  32'(q), 32'd2700);
        check("fresh_rem",   32'(r), 32'd0);
        check("fresh_err",   32'(err), 32'd0);
        @(negedge clk); i_req = '0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
